// File: rtl/qam16_symbol_mapper.sv
// 16-QAM transmit symbol mapper: Gray-maps 4-bit symbols to 1s17 I/Q.
// Frames the stream with a max-level preamble and fills underflow from a PRBS.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   sym_clk_ena           one-cycle symbol tick
//   tx_enable             run/stop control, sampled on ticks
//   in_valid, in_data     input symbol ([3:2] -> I, [1:0] -> Q)
//   in_ready              tick cycle while in DATA (combinational)
//   out_i, out_q          registered signed I/Q symbol
//   sym_valid             pulse when out_i/out_q update
//   frame_start           pulse with preamble symbol 0
//   underflow_cnt         saturating count of PRBS-filled symbols
module qam16_symbol_mapper #(
  parameter int DATA_WIDTH = 18,
  parameter logic signed [DATA_WIDTH-1:0] LEVEL_A = 18'sd32768,
  parameter int PREAMBLE_LEN = 16,
  parameter int FRAME_LEN = 1024,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sym_clk_ena,
  input  logic                         tx_enable,
  input  logic                         in_valid,
  input  logic [3:0]                   in_data,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] out_i,
  output logic signed [DATA_WIDTH-1:0] out_q,
  output logic                         sym_valid,
  output logic                         frame_start,
  output logic [CNT_WIDTH-1:0]         underflow_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA
  } state_t;

  localparam logic signed [DATA_WIDTH-1:0] LV_P1 = LEVEL_A;
  localparam logic signed [DATA_WIDTH-1:0] LV_P3 =
    DATA_WIDTH'(3 * LEVEL_A);
  localparam logic signed [DATA_WIDTH-1:0] LV_N1 = -LV_P1;
  localparam logic signed [DATA_WIDTH-1:0] LV_N3 = -LV_P3;

  localparam logic [CNT_WIDTH-1:0] PRE_LAST =
    CNT_WIDTH'(PREAMBLE_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] DATA_LAST =
    CNT_WIDTH'(FRAME_LEN - 1);

  state_t                  r_state;
  // Index of the next symbol within the current state.
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [14:0]             r_lfsr;
  logic [CNT_WIDTH-1:0]    r_ufl;
  logic signed [DATA_WIDTH-1:0] r_i;
  logic signed [DATA_WIDTH-1:0] r_q;
  logic                    r_sym_valid;
  logic                    r_frame_start;

  logic [3:0]              w_sym;
  logic                    w_fb;

  function automatic logic signed [DATA_WIDTH-1:0] f_map(
    input logic [1:0] b
  );
    logic signed [DATA_WIDTH-1:0] v;
    v = '0;
    unique case (b)
      2'b00: v = LV_N3;
      2'b01: v = LV_N1;
      2'b11: v = LV_P1;
      2'b10: v = LV_P3;
    endcase
    return v;
  endfunction

  // Underflow symbols come from the low LFSR nibble.
  assign w_sym = in_valid ? in_data : r_lfsr[3:0];
  // x^15 + x^14 + 1, shifting left.
  assign w_fb = r_lfsr[14] ^ r_lfsr[13];

  assign in_ready = sym_clk_ena & (r_state == S_DATA);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_lfsr        <= 15'h7FFF;
      r_ufl         <= '0;
      r_i           <= '0;
      r_q           <= '0;
      r_sym_valid   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_sym_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      if (sym_clk_ena) begin
        r_sym_valid <= 1'b1;
        if (!tx_enable) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_i     <= '0;
          r_q     <= '0;
        end else begin
          unique case (r_state)
            S_IDLE: begin
              // This tick already carries preamble symbol 0.
              r_state       <= S_PRE;
              r_cnt         <= CNT_WIDTH'(1);
              r_i           <= LV_P3;
              r_q           <= LV_P3;
              r_frame_start <= 1'b1;
            end
            S_PRE: begin
              r_frame_start <= (r_cnt == '0);
              r_i <= r_cnt[0] ? LV_N3 : LV_P3;
              r_q <= r_cnt[0] ? LV_N3 : LV_P3;
              if (r_cnt == PRE_LAST) begin
                r_state <= S_DATA;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            S_DATA: begin
              r_i <= f_map(w_sym[3:2]);
              r_q <= f_map(w_sym[1:0]);
              if (!in_valid) begin
                r_lfsr <= {r_lfsr[13:0], w_fb};
                if (r_ufl != '1) begin
                  r_ufl <= r_ufl + 1'b1;
                end
              end
              if (r_cnt == DATA_LAST) begin
                r_state <= S_PRE;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            default: begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign out_i         = r_i;
  assign out_q         = r_q;
  assign sym_valid     = r_sym_valid;
  assign frame_start   = r_frame_start;
  assign underflow_cnt = r_ufl;

endmodule
